letter_glyph_drawer: RTL and testbench

//  Renders one 5x7 character glyph into the 160x120 vga_adapter frame buffer, one pixel per cycle.

---
 rtl/hangman_pkg.sv | 19 +
 rtl/font_rom_5x7.sv | 45 ++++
 rtl/letter_glyph_drawer.sv | 77 +++++++
 tb/tb_letter_glyph_drawer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// hangman_pkg: screen, glyph and key constants plus drawer state encoding
package hangman_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int GLYPH_W = 5;
    localparam int GLYPH_H = 7;
    localparam logic [7:0] KEY_ENTER = 8'h0A;
    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_UNDERSCORE = 8'h5F;
    localparam logic [4:0] GLYPH_UNDERSCORE = 5'd26;
    localparam logic [4:0] GLYPH_BLANK = 5'd27;
    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} drawer_state_t;
    // Lowercase folds onto the same font entries as uppercase.
    function automatic logic [4:0] glyph_index(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) ? 5'(c - 8'h41)
             : (c >= 8'h61 && c <= 8'h7A) ? 5'(c - 8'h61)
             : (c == KEY_UNDERSCORE) ? GLYPH_UNDERSCORE : GLYPH_BLANK;
    endfunction
endpackage

// File: rtl/font_rom_5x7.sv
// font_rom_5x7: combinational 5x7 font, glyph 0-25 A-Z, 26 underscore, 27 blank
//  glyph in 5  glyph index
//  row   in 3  glyph row, 0 is top
//  bits  out 5 row bitmap, bit 4 is the leftmost column
module font_rom_5x7 (
    input  logic [4:0] glyph,
    input  logic [2:0] row,
    output logic [4:0] bits
);
    logic [34:0] g;
    always_comb begin
        g = '0;
        case (glyph)
            5'd0:  g = 35'b01110_10001_10001_11111_10001_10001_10001;
            5'd1:  g = 35'b11110_10001_10001_11110_10001_10001_11110;
            5'd2:  g = 35'b01110_10001_10000_10000_10000_10001_01110;
            5'd3:  g = 35'b11110_10001_10001_10001_10001_10001_11110;
            5'd4:  g = 35'b11111_10000_10000_11110_10000_10000_11111;
            5'd5:  g = 35'b11111_10000_10000_11110_10000_10000_10000;
            5'd6:  g = 35'b01110_10001_10000_10111_10001_10001_01111;
            5'd7:  g = 35'b10001_10001_10001_11111_10001_10001_10001;
            5'd8:  g = 35'b01110_00100_00100_00100_00100_00100_01110;
            5'd9:  g = 35'b00111_00010_00010_00010_00010_10010_01100;
            5'd10: g = 35'b10001_10010_10100_11000_10100_10010_10001;
            5'd11: g = 35'b10000_10000_10000_10000_10000_10000_11111;
            5'd12: g = 35'b10001_11011_10101_10101_10001_10001_10001;
            5'd13: g = 35'b10001_10001_11001_10101_10011_10001_10001;
            5'd14: g = 35'b01110_10001_10001_10001_10001_10001_01110;
            5'd15: g = 35'b11110_10001_10001_11110_10000_10000_10000;
            5'd16: g = 35'b01110_10001_10001_10001_10101_10010_01101;
            5'd17: g = 35'b11110_10001_10001_11110_10100_10010_10001;
            5'd18: g = 35'b01111_10000_10000_01110_00001_00001_11110;
            5'd19: g = 35'b11111_00100_00100_00100_00100_00100_00100;
            5'd20: g = 35'b10001_10001_10001_10001_10001_10001_01110;
            5'd21: g = 35'b10001_10001_10001_10001_10001_01010_00100;
            5'd22: g = 35'b10001_10001_10001_10101_10101_10101_01010;
            5'd23: g = 35'b10001_10001_01010_00100_01010_10001_10001;
            5'd24: g = 35'b10001_10001_01010_00100_00100_00100_00100;
            5'd25: g = 35'b11111_00001_00010_00100_01000_10000_11111;
            5'd26: g = 35'b00000_00000_00000_00000_00000_00000_11111;
            default: g = '0;
        endcase
        bits = 5'(g >> (5 * (3'd6 - row)));
    end
endmodule

// File: rtl/letter_glyph_drawer.sv
// letter_glyph_drawer: draws one 5x7 glyph into a word slot, one pixel per cycle
//  clock, reset             clock and synchronous active-high reset
//  start, letter, slot,     draw request; letter/slot/fg_colour captured on accept
//  fg_colour
//  x, y, colour, plot       pixel write to vga_adapter
//  busy, done               busy from cycle after accept through done; done one-cycle pulse
module letter_glyph_drawer
    import hangman_pkg::*;
#(
    parameter int ORIGIN_X = 8,
    parameter int ORIGIN_Y = 90,
    parameter int SLOT_PITCH = 8,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int NUM_SLOTS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] letter,
    input  logic [3:0] slot,
    input  logic [2:0] fg_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    drawer_state_t state, state_n;
    logic [2:0] col, row, fg_q;
    logic [7:0] letter_q, px;
    logic [3:0] slot_q;
    logic [6:0] py;
    logic [4:0] glyph, row_bits;
    logic accept, last_col, draw;
    font_rom_5x7 u_font (.glyph(glyph), .row(row), .bits(row_bits));
    always_comb begin
        glyph = glyph_index(letter_q);
        accept = state == S_IDLE && start;
        last_col = col == 3'(GLYPH_W - 1);
        draw = state == S_DRAW;
        state_n = state == S_IDLE ? (start ? (slot < 4'(NUM_SLOTS) ? S_DRAW : S_DONE) : S_IDLE)
                : draw ? (last_col && row == 3'(GLYPH_H - 1) ? S_DONE : S_DRAW)
                : S_IDLE;
        px = 8'(ORIGIN_X + int'(slot_q) * SLOT_PITCH + int'(col));
        py = 7'(ORIGIN_Y + int'(row));
        x = draw ? px : '0;
        y = draw ? py : '0;
        colour = draw ? (row_bits[3'd4 - col] ? fg_q : BG_COLOUR) : '0;
        // Off-screen pixels still take their cycle, only the write is dropped.
        plot = draw && int'(px) < SCREEN_W && int'(py) < SCREEN_H;
        busy = state != S_IDLE;
        done = state == S_DONE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            col <= '0;
            row <= '0;
            letter_q <= '0;
            slot_q <= '0;
            fg_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                letter_q <= letter;
                slot_q <= slot;
                fg_q <= fg_colour;
                col <= '0;
                row <= '0;
            end else if (draw) begin
                col <= last_col ? '0 : col + 3'd1;
                row <= last_col ? row + 3'd1 : row;
            end
        end
    end
endmodule

// File: tb/tb_letter_glyph_drawer.sv
// tb_letter_glyph_drawer: directed and random draws checked against a pixel-list model
module tb_letter_glyph_drawer;
    logic clock = 0, reset = 1, start = 0, plot, busy, done;
    logic [7:0] letter = 0, x;
    logic [3:0] slot = 0;
    logic [2:0] fg_colour = 0, colour;
    logic [6:0] y;
    int checks = 0, errors = 0;

    letter_glyph_drawer dut (
        .clock(clock), .reset(reset), .start(start), .letter(letter), .slot(slot),
        .fg_colour(fg_colour), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Reference glyphs A-Z, row-major, bit 34 is pixel (0,0).
    logic [34:0] font [26] = '{
        35'b01110_10001_10001_11111_10001_10001_10001,
        35'b11110_10001_10001_11110_10001_10001_11110,
        35'b01110_10001_10000_10000_10000_10001_01110,
        35'b11110_10001_10001_10001_10001_10001_11110,
        35'b11111_10000_10000_11110_10000_10000_11111,
        35'b11111_10000_10000_11110_10000_10000_10000,
        35'b01110_10001_10000_10111_10001_10001_01111,
        35'b10001_10001_10001_11111_10001_10001_10001,
        35'b01110_00100_00100_00100_00100_00100_01110,
        35'b00111_00010_00010_00010_00010_10010_01100,
        35'b10001_10010_10100_11000_10100_10010_10001,
        35'b10000_10000_10000_10000_10000_10000_11111,
        35'b10001_11011_10101_10101_10001_10001_10001,
        35'b10001_10001_11001_10101_10011_10001_10001,
        35'b01110_10001_10001_10001_10001_10001_01110,
        35'b11110_10001_10001_11110_10000_10000_10000,
        35'b01110_10001_10001_10001_10101_10010_01101,
        35'b11110_10001_10001_11110_10100_10010_10001,
        35'b01111_10000_10000_01110_00001_00001_11110,
        35'b11111_00100_00100_00100_00100_00100_00100,
        35'b10001_10001_10001_10001_10001_10001_01110,
        35'b10001_10001_10001_10001_10001_01010_00100,
        35'b10001_10001_10001_10101_10101_10101_01010,
        35'b10001_10001_01010_00100_01010_10001_10001,
        35'b10001_10001_01010_00100_00100_00100_00100,
        35'b11111_00001_00010_00100_01000_10000_11111
    };

    // Observed bundle: {plot, busy, done, x, y, colour}
    function automatic logic [20:0] sample();
        return {plot, busy, done, x, y, colour};
    endfunction

    function automatic logic [20:0] exp_pixel(input logic [7:0] l, input logic [3:0] s,
                                              input logic [2:0] f, input int k);
        logic [7:0] u;
        logic on;
        int col, row;
        col = k % 5;
        row = k / 5;
        u = (l >= 8'h61 && l <= 8'h7A) ? l - 8'h20 : l;
        on = (u >= 8'h41 && u <= 8'h5A) ? font[u - 8'h41][34 - k] : (u == 8'h5F) ? (row == 6) : 1'b0;
        return {1'b1, 1'b1, 1'b0, 8'(8 + 8 * s + col), 7'(90 + row), on ? f : 3'b000};
    endfunction

    task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at the sample point right after the accepting edge; ends on the done cycle.
    task automatic expect_body(input logic [7:0] l, input logic [3:0] s, input logic [2:0] f,
                               input bit poke);
        if (s >= 10) begin
            chk("oor_done", sample(), {1'b0, 1'b1, 1'b1, 18'd0});
            return;
        end
        for (int k = 0; k < 35; k++) begin
            chk($sformatf("pix%0d", k), sample(), exp_pixel(l, s, f, k));
            if (k == 10) begin
                letter = 8'($urandom);
                slot = 4'($urandom);
                fg_colour = 3'($urandom);
            end
            if (poke && k == 20) start = 1;
            if (poke && k == 25) start = 0;
            @(posedge clock); #1;
        end
        chk("done_pulse", sample(), {1'b0, 1'b1, 1'b1, 18'd0});
    endtask

    task automatic draw(input logic [7:0] l, input logic [3:0] s, input logic [2:0] f,
                        input bit poke);
        letter = l;
        slot = s;
        fg_colour = f;
        start = 1;
        @(posedge clock); #1;
        start = 0;
        expect_body(l, s, f, poke);
        @(posedge clock); #1;
        chk("idle_after", sample(), '0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset", sample(), '0);
        reset = 0;
        @(posedge clock); #1;
        chk("idle", sample(), '0);
        draw(8'h41, 4'd0, 3'b111, 0);
        chk("a_2_0", 21'(exp_pixel(8'h41, 4'd0, 3'b111, 2) & 21'h7), 21'd7);
        draw(8'h5F, 4'd9, 3'b101, 1);
        draw(8'h61, 4'd3, 3'b011, 0);
        draw(8'h41, 4'd3, 3'b011, 0);
        draw(8'h0A, 4'd3, 3'b111, 0);
        draw(8'h00, 4'd5, 3'b111, 1);
        draw(8'h41, 4'd10, 3'b111, 0);
        draw(8'h5A, 4'd15, 3'b010, 0);
        // Start held across two draws.
        letter = 8'h48;
        slot = 4'd2;
        fg_colour = 3'b110;
        start = 1;
        @(posedge clock); #1;
        expect_body(8'h48, 4'd2, 3'b110, 0);
        @(posedge clock); #1;
        chk("b2b_gap", sample(), '0);
        letter = 8'h7A;
        slot = 4'd4;
        fg_colour = 3'b011;
        @(posedge clock); #1;
        expect_body(8'h7A, 4'd4, 3'b011, 0);
        start = 0;
        @(posedge clock); #1;
        chk("b2b_idle", sample(), '0);
        // Reset in the middle of a draw.
        letter = 8'h4D;
        slot = 4'd1;
        fg_colour = 3'b111;
        start = 1;
        @(posedge clock); #1;
        start = 0;
        repeat (17) begin
            @(posedge clock); #1;
        end
        chk("pix17_pre_rst", sample(), exp_pixel(8'h4D, 4'd1, 3'b111, 17));
        reset = 1;
        @(posedge clock); #1;
        chk("rst_mid", sample(), '0);
        reset = 0;
        repeat (3) begin
            @(posedge clock); #1;
            chk("no_done_after_rst", sample(), '0);
        end
        draw(8'h4D, 4'd1, 3'b111, 0);
        for (int i = 0; i < 24; i++) begin
            logic [7:0] l;
            l = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'h41, 8'h7A));
            draw(l, 4'($urandom_range(0, 11)), 3'($urandom), bit'(i % 2));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
